sseg_display_mux: RTL and testbench

- Display-side consumer of the reaction-timer digit interface (`digit3..digit0`, `ltr_flag`).
- Time-multiplexes four 4-bit digit codes onto a common-anode 4-digit seven-segment display.
- Decodes numeric or letter glyphs, inserts a per-slot anti-ghosting blank interval, and updates digit values only at frame boundaries so the display never shows a torn frame.

---
 rtl/sseg_display_mux.sv | 95 +++++++++
 tb/tb_sseg_display_mux.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/sseg_display_mux.sv
// Four-digit common-anode seven-segment multiplexer with per-slot blanking.
// Digit values are shadowed once per frame so a frame is never torn.
module sseg_display_mux #(
  parameter int N      = 18,
  parameter int BLANK  = 16,
  parameter int DP_POS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ltr_flag,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  input  logic [3:0] digit2,
  input  logic [3:0] digit3,
  input  logic       dp_en,
  output logic [3:0] an,
  output logic [7:0] sseg
);

  localparam logic [N-3:0] BLANK_W = (N-2)'(BLANK);
  localparam logic [1:0]   DP_SLOT = 2'(DP_POS);

  logic [N-1:0]      cnt_q;
  logic [3:0][3:0]   dig_q;
  logic              ltr_q;
  logic              dp_q;
  logic [3:0]        an_q, an_d;
  logic [7:0]        sseg_q, sseg_d;

  logic [1:0]        slot;
  logic [N-3:0]      offs;
  logic [3:0]        code;
  logic [6:0]        seg;
  logic              frame_end;

  always_comb begin
    slot      = cnt_q[N-1:N-2];
    offs      = cnt_q[N-3:0];
    code      = dig_q[slot];
    frame_end = &cnt_q;
    seg       = 7'h7F;
    if (ltr_q) begin
      case (code)
        4'h5:    seg = 7'h09;
        4'hA:    seg = 7'h79;
        default: seg = 7'h7F;
      endcase
    end else begin
      case (code)
        4'd0:    seg = 7'h40;
        4'd1:    seg = 7'h79;
        4'd2:    seg = 7'h24;
        4'd3:    seg = 7'h30;
        4'd4:    seg = 7'h19;
        4'd5:    seg = 7'h12;
        4'd6:    seg = 7'h02;
        4'd7:    seg = 7'h78;
        4'd8:    seg = 7'h00;
        4'd9:    seg = 7'h10;
        default: seg = 7'h7F;
      endcase
    end
    an_d   = ~(4'b0001 << slot);
    sseg_d = {~(dp_q & ~ltr_q & (slot == DP_SLOT)), seg};
    if (offs < BLANK_W) begin
      an_d   = '1;
      sseg_d = '1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      dig_q  <= '1;
      ltr_q  <= 1'b0;
      dp_q   <= 1'b0;
      an_q   <= '1;
      sseg_q <= '1;
    end else begin
      cnt_q  <= cnt_q + 1'b1;
      an_q   <= an_d;
      sseg_q <= sseg_d;
      // Snapshot lands on the wrap edge, so the new frame starts with new values.
      if (frame_end) begin
        dig_q <= {digit3, digit2, digit1, digit0};
        ltr_q <= ltr_flag;
        dp_q  <= dp_en;
      end
    end
  end

  assign an   = an_q;
  assign sseg = sseg_q;

endmodule

// File: tb/tb_sseg_display_mux.sv
// Scoreboard bench for sseg_display_mux with N=6, BLANK=2 (16-clk slots, 64-clk frames).
module tb_sseg_display_mux;

  localparam int FRAME = 64;
  localparam int SLOT  = 16;
  localparam int BLNK  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ltr_flag = 1'b0;
  logic [3:0] digit0 = '0, digit1 = '0, digit2 = '0, digit3 = '0;
  logic       dp_en = 1'b0;
  logic [3:0] an;
  logic [7:0] sseg;

  int n_cmp = 0;
  int n_err = 0;

  sseg_display_mux #(.N(6), .BLANK(BLNK), .DP_POS(3)) dut (
    .clk(clk), .rst(rst), .ltr_flag(ltr_flag),
    .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
    .dp_en(dp_en), .an(an), .sseg(sseg)
  );

  always #5 clk = ~clk;

  // Reference model: frame position, shadowed frame contents, glyph tables.
  int         m = 0;
  logic [3:0] sh_dig [4] = '{4'hF, 4'hF, 4'hF, 4'hF};
  logic       sh_ltr = 1'b0;
  logic       sh_dp  = 1'b0;
  logic [11:0] exp_q [$];

  logic [7:0] num_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  logic [3:0] an_tab  [4]  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  function automatic logic [11:0] expect_at(input int pos);
    int         s, o;
    logic [3:0] c;
    logic [7:0] g;
    s = pos / SLOT;
    o = pos % SLOT;
    if (o < BLNK) return {4'hF, 8'hFF};
    c = sh_dig[s];
    if (sh_ltr) g = (c == 4'h5) ? 8'h89 : (c == 4'hA) ? 8'hF9 : 8'hFF;
    else        g = (c < 10) ? num_tab[c] : 8'hFF;
    if (sh_dp && !sh_ltr && s == 3) g = g & 8'h7F;
    return {an_tab[s], g};
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      m = 0;
      sh_dig = '{4'hF, 4'hF, 4'hF, 4'hF};
      sh_ltr = 1'b0;
      sh_dp  = 1'b0;
    end else begin
      exp_q.push_back(expect_at(m));
      if (m == FRAME - 1) begin
        sh_dig = '{digit0, digit1, digit2, digit3};
        sh_ltr = ltr_flag;
        sh_dp  = dp_en;
      end
      m = (m + 1) % FRAME;
    end
  end

  // Monitor: one registered output word per clock.
  always @(negedge clk) begin
    logic [11:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if ({an, sseg} !== e) begin
        n_err++;
        $display("FAIL frame_out t=%0t got an=%b sseg=%h want an=%b sseg=%h",
                 $time, an, sseg, e[11:8], e[7:0]);
      end
      n_cmp++;
      if ($countones(~an) > 1) begin
        n_err++;
        $display("FAIL onehot_an t=%0t got an=%b want at most one low bit", $time, an);
      end
    end
  end

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s got %h want %h", name, act, req);
    end
  endtask

  task automatic wait_m(input int v);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (m != v && k < 300);
    n_cmp++;
    if (m != v) begin
      n_err++;
      $display("FAIL wait_pos got %0d want %0d", m, v);
    end
  endtask

  task automatic set_in(input logic [3:0] d3, d2, d1, d0, input logic l, input logic dp);
    digit3 = d3; digit2 = d2; digit1 = d1; digit0 = d0;
    ltr_flag = l; dp_en = dp;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (5) @(negedge clk);
    check("reset_state", {an, sseg}, {4'hF, 8'hFF});
    rst = 1'b1;
    // First frame must stay blank even though inputs already carry 1,2,3,4.
    set_in(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 1'b1);
    wait_m(0);
    set_in(4'hF, 4'hF, 4'h5, 4'hA, 1'b1, 1'b1);
    wait_m(1);
    wait_m(0);
    set_in(4'd9, 4'd9, 4'd9, 4'd9, 1'b0, 1'b0);
    wait_m(1);
    wait_m(0);
    wait_m(20);
    set_in(4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    wait_m(0);
    set_in(4'hC, 4'd7, 4'hC, 4'd8, 1'b0, 1'b1);
    wait_m(1);
    wait_m(0);
    // Random frames: inputs change at arbitrary points, only the wrap snapshot matters.
    repeat (FRAME * 8) begin
      @(negedge clk);
      if ($urandom_range(7) == 0)
        set_in(4'($urandom), 4'($urandom), 4'($urandom),
               ($urandom_range(1) == 1) ? 4'h5 : 4'hA,
               1'($urandom), 1'($urandom));
    end
    wait_m(37);
    #1 rst = 1'b0;
    #1 check("async_reset", {an, sseg}, {4'hF, 8'hFF});
    repeat (3) @(negedge clk);
    check("reset_hold", {an, sseg}, {4'hF, 8'hFF});
    rst = 1'b1;
    set_in(4'd6, 4'd5, 4'd2, 4'd8, 1'b0, 1'b1);
    repeat (FRAME * 2 + 5) begin
      @(negedge clk);
      if ($urandom_range(15) == 0)
        set_in(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
               1'($urandom), 1'($urandom));
    end
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
